data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single data_ram port between two requesters: the pipeline load/store path (core port, from the stage-3 datapath) and a DMA/debug master (dma port).
- Issues at most one access per cycle and routes the one-cycle-latency read response back to the requester that issued it.
- Raises a stall toward the pipeline whenever the core's access is not granted.
- Bounds DMA starvation with a consecutive-core-grant limit, and supports a locked DMA burst.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits; byte enables are DW/8 bits wide.
- MAX_CORE_RUN, 4, maximum consecutive core grants while DMA is waiting. Legal range is 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- core_req_i  in  1  core access request.
- core_we_i  in  1  core write enable.
- core_be_i  in  DW/8  core byte enables.
- core_addr_i  in  AW  core byte address.
- core_wdata_i  in  DW  core write data.
- core_stall_o  out  1  high when core_req_i is high and the core is not granted this cycle.
- core_rvalid_o  out  1  core read data valid.
- core_rdata_o  out  DW  core read data.
- dma_req_i  in  1  DMA access request.
- dma_lock_i  in  1  hold the grant for a DMA burst.
- dma_we_i  in  1  DMA write enable.
- dma_be_i  in  DW/8  DMA byte enables.
- dma_addr_i  in  AW  DMA byte address.
- dma_wdata_i  in  DW  DMA write data.
- dma_gnt_o  out  1  DMA access accepted this cycle.
- dma_rvalid_o  out  1  DMA read data valid.
- dma_rdata_o  out  DW  DMA read data.
- dma_err_o  out  1  one-cycle pulse: a DMA access was rejected as misaligned.
- mem_we_o  out  1  RAM write enable.
- mem_be_o  out  DW/8  RAM byte enables.
- mem_addr_o  out  AW  RAM address.
- mem_wdata_o  out  DW  RAM write data.
- mem_rdata_i  in  DW  RAM read data, valid the cycle after the read is issued.

Behaviour:
- Reset (rst_i low, asynchronous): state=ARB, run_cnt=0, resp_owner=NONE. All rvalid/gnt/err/we outputs are 0 and mem_be_o is 0.
  - core_stall_o is purely combinational from core_req_i and the grant, so it equals core_req_i while reset is held (nothing is granted).
  - Deasserting reset mid-access drops any pending response; no rvalid is produced for it.
- Grant decision is combinational on the current inputs.
  - In state ARB, the core wins by default.
  - The DMA wins if core_req_i=0, or if run_cnt==MAX_CORE_RUN and dma_req_i=1.
  - The granted requester's fields drive mem_*. When nothing is granted, mem_we_o=0, mem_be_o=0, and address/data hold their last values.
- run_cnt:
  - Increments on each core grant while dma_req_i=1; saturates at MAX_CORE_RUN.
  - Clears on any DMA grant or on any cycle with dma_req_i=0.
- States:
  - ARB is the normal per-cycle arbitration.
  - DMA_LOCK is entered when the DMA is granted with dma_lock_i=1. While in DMA_LOCK, the DMA wins every cycle; the core stalls if requesting.
  - Return to ARB occurs on the first cycle with dma_lock_i=0. That cycle is itself arbitrated as ARB.
  - dma_req_i=0 while locked is an idle cycle: no access, lock held.
- Misalignment:
  - A DMA request is misaligned if dma_be_i is not one of 1/2/4/8 (byte), 3/C (half), or F (word).
  - A misaligned DMA request is never issued to the RAM. dma_gnt_o=1, dma_err_o=1, no rvalid follows, and it does not affect run_cnt or the lock.
  - Core requests are not checked.
- Response routing:
  - Each issued read (we=0) sets resp_owner for the next cycle.
  - The next cycle, the owner's rvalid=1 and its rdata=mem_rdata_i. The other rdata holds its last value.
  - Writes produce no rvalid.
  - Back-to-back reads from alternating owners route correctly cycle by cycle.
- Simultaneous events:
  - Core and DMA requesting in the same cycle: resolved by the grant rule above; exactly one access is issued.
  - A write and a read response in the same cycle are independent.
- Widths: no arithmetic on addresses; the arbiter passes them through. run_cnt is 4 bits.

Test Plan:
- Reset: hold rst_i=0 with core_req_i=1 and dma_req_i=1 -> gnt=0, rvalid=0, mem_we_o=0, mem_be_o=0, core_stall_o=1. Release rst_i -> the first grant goes to the core.
- Core read: core read at 0x100 with RAM word 0xDEADBEEF -> core_stall_o=0 that cycle; next cycle core_rvalid_o=1, core_rdata_o=0xDEADBEEF, dma_rvalid_o=0.
- Starvation bound: continuous core and DMA requests with MAX_CORE_RUN=4 -> grant pattern C,C,C,C,D,C,C,C,C,D; core_stall_o=1 exactly on the D cycles.
- Locked burst: DMA writes 0x11,0x22,0x33 to 0x200..0x208 with dma_lock_i=1, core requesting throughout -> 3 consecutive DMA grants with core_stall_o=1. Lock drops and core_req_i=1 -> core granted the next cycle.
- Misaligned DMA: dma_be_i=4'b0110 -> dma_gnt_o=1, dma_err_o=1, mem_we_o=0, mem_be_o=0, no dma_rvalid_o. Core on the same cycle is unaffected.
- Interleaved reads, reset mid-operation: alternating core/DMA reads each return to their own port one cycle later. Asserting rst_i during a pending read -> no rvalid after reset release.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter for the single data RAM port: pipeline core vs. DMA/debug master.
// Combinational grant, bounded core run, locked DMA bursts, one-cycle read response routing.
module data_mem_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned MAX_CORE_RUN = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            core_req_i,
    input  logic            core_we_i,
    input  logic [DW/8-1:0] core_be_i,
    input  logic [AW-1:0]   core_addr_i,
    input  logic [DW-1:0]   core_wdata_i,
    output logic            core_stall_o,
    output logic            core_rvalid_o,
    output logic [DW-1:0]   core_rdata_o,
    input  logic            dma_req_i,
    input  logic            dma_lock_i,
    input  logic            dma_we_i,
    input  logic [DW/8-1:0] dma_be_i,
    input  logic [AW-1:0]   dma_addr_i,
    input  logic [DW-1:0]   dma_wdata_i,
    output logic            dma_gnt_o,
    output logic            dma_rvalid_o,
    output logic [DW-1:0]   dma_rdata_o,
    output logic            dma_err_o,
    output logic            mem_we_o,
    output logic [DW/8-1:0] mem_be_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    input  logic [DW-1:0]   mem_rdata_i
);
    localparam int unsigned BW = DW / 8;

    typedef enum logic {StArb, StDmaLock} state_e;
    typedef enum logic [1:0] {OwnNone, OwnCore, OwnDma} owner_e;

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [3:0]    run_cnt_q, run_cnt_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] core_rdata_q, dma_rdata_q;

    logic dma_aligned, dma_ok, dma_bad, run_max;
    logic core_win, dma_win;

    always_comb begin
        dma_aligned = 1'b0;
        case (dma_be_i)
            BW'(1), BW'(2), BW'(4), BW'(8), BW'(3), BW'(12), BW'(15): dma_aligned = 1'b1;
            default: dma_aligned = 1'b0;
        endcase
    end

    // Misaligned DMA requests are acknowledged with an error and never reach the RAM.
    assign dma_ok  = dma_req_i && dma_aligned;
    assign dma_bad = rst_i && dma_req_i && !dma_aligned;
    assign run_max = (run_cnt_q == 4'(MAX_CORE_RUN));

    always_comb begin
        core_win = 1'b0;
        dma_win  = 1'b0;
        if (rst_i) begin
            if (state_q == StDmaLock && dma_lock_i) begin
                dma_win = dma_ok;
            end else begin
                dma_win  = dma_ok && (!core_req_i || run_max);
                core_win = core_req_i && !dma_win;
            end
        end
    end

    assign core_stall_o = core_req_i && !core_win;
    assign dma_gnt_o    = dma_win || dma_bad;
    assign dma_err_o    = dma_bad;

    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        if (core_win) begin
            mem_we_o    = core_we_i;
            mem_be_o    = core_be_i;
            mem_addr_o  = core_addr_i;
            mem_wdata_o = core_wdata_i;
        end else if (dma_win) begin
            mem_we_o    = dma_we_i;
            mem_be_o    = dma_be_i;
            mem_addr_o  = dma_addr_i;
            mem_wdata_o = dma_wdata_i;
        end
    end

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (dma_win || !dma_req_i) begin
            run_cnt_d = '0;
        end else if (core_win && !dma_bad && !run_max) begin
            run_cnt_d = run_cnt_q + 4'd1;
        end

        state_d = state_q;
        if (dma_win && dma_lock_i) begin
            state_d = StDmaLock;
        end else if (!dma_lock_i) begin
            state_d = StArb;
        end

        owner_d = OwnNone;
        if (core_win && !core_we_i) begin
            owner_d = OwnCore;
        end else if (dma_win && !dma_we_i) begin
            owner_d = OwnDma;
        end
    end

    assign core_rvalid_o = (owner_q == OwnCore);
    assign dma_rvalid_o  = (owner_q == OwnDma);
    assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : core_rdata_q;
    assign dma_rdata_o   = dma_rvalid_o ? mem_rdata_i : dma_rdata_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= StArb;
            owner_q      <= OwnNone;
            run_cnt_q    <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_rdata_q <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            run_cnt_q    <= run_cnt_d;
            addr_q       <= mem_addr_o;
            wdata_q      <= mem_wdata_o;
            core_rdata_q <= core_rdata_o;
            dma_rdata_q  <= dma_rdata_o;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level reference model with its own shadow of the RAM.
module tb_data_mem_arbiter;
    localparam int MAXRUN = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        core_req_i, core_we_i;
    logic [3:0]  core_be_i;
    logic [31:0] core_addr_i, core_wdata_i;
    logic        core_stall_o, core_rvalid_o;
    logic [31:0] core_rdata_o;
    logic        dma_req_i, dma_lock_i, dma_we_i;
    logic [3:0]  dma_be_i;
    logic [31:0] dma_addr_i, dma_wdata_i;
    logic        dma_gnt_o, dma_rvalid_o, dma_err_o;
    logic [31:0] dma_rdata_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    int n_checks = 0;
    int n_fail   = 0;

    // RAM model; backdoor writes come through this block only.
    logic [31:0] ram [256];
    logic        bd_we, bd_fill;
    logic [7:0]  bd_idx;
    logic [31:0] bd_data;
    logic [31:0] shadow [256];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bd_fill) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'hA5A5_0000 ^ (i * 32'h0101_0101);
        end else if (bd_we) begin
            ram[bd_idx] <= bd_data;
        end else if (mem_be_o != 4'h0) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) ram[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                mem_rdata_i <= ram[mem_addr_o[9:2]];
            end
        end
    end

    data_mem_arbiter #(.AW(32), .DW(32), .MAX_CORE_RUN(MAXRUN)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_be_i(core_be_i),
        .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
        .core_stall_o(core_stall_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
        .dma_req_i(dma_req_i), .dma_lock_i(dma_lock_i), .dma_we_i(dma_we_i),
        .dma_be_i(dma_be_i), .dma_addr_i(dma_addr_i), .dma_wdata_i(dma_wdata_i),
        .dma_gnt_o(dma_gnt_o), .dma_rvalid_o(dma_rvalid_o), .dma_rdata_o(dma_rdata_o),
        .dma_err_o(dma_err_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    task automatic idle_inputs();
        core_req_i = 0; core_we_i = 0; core_be_i = 4'h0; core_addr_i = 0; core_wdata_i = 0;
        dma_req_i = 0; dma_lock_i = 0; dma_we_i = 0; dma_be_i = 4'h0; dma_addr_i = 0;
        dma_wdata_i = 0;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        bd_idx = idx; bd_data = data; bd_we = 1;
        @(negedge clk);
        bd_we = 0;
    endtask

    // Ends on a negedge with reset released, ready for the first stimulus cycle.
    task automatic do_reset();
        idle_inputs();
        rst_i = 0;
        repeat (2) @(negedge clk);
        rst_i = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 0;
        core_req_i = 1; core_be_i = 4'hF; core_addr_i = 32'h40;
        dma_req_i = 1; dma_be_i = 4'hF; dma_addr_i = 32'h80;
        #1;
        n_checks++; if (dma_gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got %b want 0", dma_gnt_o); end
        n_checks++; if ({core_rvalid_o, dma_rvalid_o} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got %b want 00", {core_rvalid_o, dma_rvalid_o}); end
        n_checks++; if (mem_we_o !== 1'b0 || mem_be_o !== 4'h0) begin n_fail++; $display("FAIL reset_mem got we=%b be=%h want 0/0", mem_we_o, mem_be_o); end
        n_checks++; if (core_stall_o !== 1'b1) begin n_fail++; $display("FAIL reset_stall got %b want 1", core_stall_o); end
        n_checks++; if (dma_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", dma_err_o); end
        @(negedge clk);
        rst_i = 1;
        #1;
        n_checks++; if (core_stall_o !== 1'b0 || dma_gnt_o !== 1'b0) begin n_fail++; $display("FAIL first_grant got stall=%b dgnt=%b want 0/0", core_stall_o, dma_gnt_o); end
        n_checks++; if (mem_addr_o !== 32'h40) begin n_fail++; $display("FAIL first_grant_addr got %h want 00000040", mem_addr_o); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_core_read();
        preload(8'h40, 32'hDEAD_BEEF);
        do_reset();
        core_req_i = 1; core_we_i = 0; core_be_i = 4'hF; core_addr_i = 32'h100;
        #1;
        n_checks++; if (core_stall_o !== 1'b0) begin n_fail++; $display("FAIL core_read_stall got %b want 0", core_stall_o); end
        n_checks++; if (mem_addr_o !== 32'h100 || mem_be_o !== 4'hF || mem_we_o !== 1'b0) begin n_fail++; $display("FAIL core_read_mem got a=%h be=%h we=%b want 100/F/0", mem_addr_o, mem_be_o, mem_we_o); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (core_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL core_rvalid got %b want 1", core_rvalid_o); end
        n_checks++; if (core_rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL core_rdata got %h want deadbeef", core_rdata_o); end
        n_checks++; if (dma_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL core_read_dma_rvalid got %b want 0", dma_rvalid_o); end
        @(negedge clk);
    endtask

    task automatic test_starvation();
        do_reset();
        core_req_i = 1; core_be_i = 4'hF; core_addr_i = 32'h10;
        dma_req_i = 1; dma_be_i = 4'hF; dma_addr_i = 32'h20;
        for (int i = 0; i < 10; i++) begin
            logic want_d;
            want_d = (i % (MAXRUN + 1)) == MAXRUN;
            #1;
            n_checks++; if (dma_gnt_o !== want_d) begin n_fail++; $display("FAIL starve_gnt[%0d] got %b want %b", i, dma_gnt_o, want_d); end
            n_checks++; if (core_stall_o !== want_d) begin n_fail++; $display("FAIL starve_stall[%0d] got %b want %b", i, core_stall_o, want_d); end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_locked_burst();
        int waited;
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        do_reset();
        core_req_i = 1; core_be_i = 4'hF; core_addr_i = 32'h300;
        dma_req_i = 1; dma_lock_i = 1; dma_we_i = 1; dma_be_i = 4'hF;
        waited = 0;
        for (int j = 0; j < 3; j++) begin
            dma_addr_i = 32'h200 + 32'(4 * j); dma_wdata_i = vals[j];
            #1;
            while (!dma_gnt_o && waited < 8) begin
                @(negedge clk); #1; waited++;
            end
            n_checks++; if (dma_gnt_o !== 1'b1) begin n_fail++; $display("FAIL lock_gnt[%0d] got %b want 1", j, dma_gnt_o); end
            n_checks++; if (core_stall_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== dma_addr_i) begin n_fail++; $display("FAIL lock_access[%0d] got stall=%b we=%b a=%h want 1/1/%h", j, core_stall_o, mem_we_o, mem_addr_o, dma_addr_i); end
            @(negedge clk);
        end
        n_checks++; if (waited !== MAXRUN) begin n_fail++; $display("FAIL lock_core_run got %0d want %0d", waited, MAXRUN); end
        dma_req_i = 0; dma_lock_i = 0; dma_we_i = 0;
        core_addr_i = 32'h204;
        #1;
        n_checks++; if (core_stall_o !== 1'b0 || mem_addr_o !== 32'h204) begin n_fail++; $display("FAIL unlock_core got stall=%b a=%h want 0/204", core_stall_o, mem_addr_o); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (core_rvalid_o !== 1'b1 || core_rdata_o !== 32'h22) begin n_fail++; $display("FAIL burst_readback got v=%b d=%h want 1/22", core_rvalid_o, core_rdata_o); end
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        do_reset();
        dma_req_i = 1; dma_be_i = 4'b0110; dma_addr_i = 32'h200;
        #1;
        n_checks++; if (dma_gnt_o !== 1'b1 || dma_err_o !== 1'b1) begin n_fail++; $display("FAIL mis_gnt_err got %b%b want 11", dma_gnt_o, dma_err_o); end
        n_checks++; if (mem_we_o !== 1'b0 || mem_be_o !== 4'h0) begin n_fail++; $display("FAIL mis_mem got we=%b be=%h want 0/0", mem_we_o, mem_be_o); end
        @(negedge clk);
        core_req_i = 1; core_be_i = 4'hF; core_addr_i = 32'h100;
        #1;
        n_checks++; if (dma_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL mis_rvalid got %b want 0", dma_rvalid_o); end
        n_checks++; if (dma_err_o !== 1'b1 || core_stall_o !== 1'b0) begin n_fail++; $display("FAIL mis_core got err=%b stall=%b want 1/0", dma_err_o, core_stall_o); end
        n_checks++; if (mem_be_o !== 4'hF || mem_addr_o !== 32'h100) begin n_fail++; $display("FAIL mis_core_mem got be=%h a=%h want F/100", mem_be_o, mem_addr_o); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if ({core_rvalid_o, dma_rvalid_o, dma_err_o} !== 3'b100) begin n_fail++; $display("FAIL mis_after got %b want 100", {core_rvalid_o, dma_rvalid_o, dma_err_o}); end
        @(negedge clk);
    endtask

    task automatic test_interleaved_reset();
        logic [31:0] vals [4];
        vals[0] = 32'hA1A1_0001; vals[1] = 32'hB2B2_0002;
        vals[2] = 32'hC3C3_0003; vals[3] = 32'hD4D4_0004;
        for (int i = 0; i < 4; i++) preload(8'(8'h10 + i), vals[i]);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            if (i < 4) begin
                if (i % 2 == 0) begin
                    core_req_i = 1; core_be_i = 4'hF; core_addr_i = 32'h40 + 32'(4 * i);
                end else begin
                    dma_req_i = 1; dma_be_i = 4'hF; dma_addr_i = 32'h40 + 32'(4 * i);
                end
            end
            #1;
            if (i > 0) begin
                if ((i - 1) % 2 == 0) begin
                    n_checks++; if (core_rvalid_o !== 1'b1 || dma_rvalid_o !== 1'b0 || core_rdata_o !== vals[i-1]) begin n_fail++; $display("FAIL ilv_core[%0d] got cv=%b dv=%b d=%h want 1/0/%h", i, core_rvalid_o, dma_rvalid_o, core_rdata_o, vals[i-1]); end
                end else begin
                    n_checks++; if (dma_rvalid_o !== 1'b1 || core_rvalid_o !== 1'b0 || dma_rdata_o !== vals[i-1]) begin n_fail++; $display("FAIL ilv_dma[%0d] got dv=%b cv=%b d=%h want 1/0/%h", i, dma_rvalid_o, core_rvalid_o, dma_rdata_o, vals[i-1]); end
                end
            end
            @(negedge clk);
        end
        core_req_i = 1; core_be_i = 4'hF; core_addr_i = 32'h40;
        @(negedge clk);
        idle_inputs();
        rst_i = 0;
        #1;
        n_checks++; if (core_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_drop got %b want 0", core_rvalid_o); end
        @(negedge clk);
        rst_i = 1;
        #1;
        n_checks++; if ({core_rvalid_o, dma_rvalid_o} !== 2'b00) begin n_fail++; $display("FAIL rst_release got %b want 00", {core_rvalid_o, dma_rvalid_o}); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int run, owner;
        bit locked, core_known, dma_known;
        logic [31:0] pend, core_last, dma_last;
        do_reset();
        for (int i = 0; i < 256; i++) shadow[i] = ram[i];
        run = 0; owner = 0; locked = 0; core_known = 0; dma_known = 0;
        pend = 0; core_last = 0; dma_last = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit aligned, bad, dwin, cwin;
            logic [3:0] be_tab [7];
            be_tab[0] = 4'h1; be_tab[1] = 4'h2; be_tab[2] = 4'h4; be_tab[3] = 4'h8;
            be_tab[4] = 4'h3; be_tab[5] = 4'hC; be_tab[6] = 4'hF;
            core_req_i   = ($urandom % 4) != 0;
            core_we_i    = $urandom % 2;
            core_be_i    = 4'($urandom_range(1, 15));
            core_addr_i  = 32'($urandom % 64) << 2;
            core_wdata_i = $urandom;
            dma_req_i    = $urandom % 2;
            if ($urandom % 8 == 0) dma_lock_i = ~dma_lock_i;
            dma_we_i     = $urandom % 2;
            dma_be_i     = ($urandom % 4 != 0) ? be_tab[$urandom % 7] : 4'($urandom);
            dma_addr_i   = 32'($urandom % 64) << 2;
            dma_wdata_i  = $urandom;

            aligned = 0;
            for (int k = 0; k < 7; k++) if (dma_be_i == be_tab[k]) aligned = 1;
            bad = dma_req_i && !aligned;
            if (locked && dma_lock_i) begin
                dwin = dma_req_i && aligned; cwin = 0;
            end else begin
                dwin = dma_req_i && aligned && (!core_req_i || run == MAXRUN);
                cwin = core_req_i && !dwin;
            end
            #1;
            n_checks++; if (core_stall_o !== (core_req_i && !cwin)) begin n_fail++; $display("FAIL rnd_stall[%0d] got %b want %b", cyc, core_stall_o, core_req_i && !cwin); end
            n_checks++; if (dma_gnt_o !== (dwin || bad) || dma_err_o !== bad) begin n_fail++; $display("FAIL rnd_gnt_err[%0d] got %b%b want %b%b", cyc, dma_gnt_o, dma_err_o, dwin || bad, bad); end
            if (cwin || dwin) begin
                logic [31:0] ea, ed; logic ew; logic [3:0] eb;
                ea = cwin ? core_addr_i : dma_addr_i; ed = cwin ? core_wdata_i : dma_wdata_i;
                ew = cwin ? core_we_i : dma_we_i;     eb = cwin ? core_be_i : dma_be_i;
                n_checks++; if (mem_addr_o !== ea || mem_we_o !== ew || mem_be_o !== eb || (ew && mem_wdata_o !== ed)) begin n_fail++; $display("FAIL rnd_mem[%0d] got a=%h we=%b be=%h d=%h want %h/%b/%h/%h", cyc, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, ea, ew, eb, ed); end
            end else begin
                n_checks++; if (mem_we_o !== 1'b0 || mem_be_o !== 4'h0) begin n_fail++; $display("FAIL rnd_idle[%0d] got we=%b be=%h want 0/0", cyc, mem_we_o, mem_be_o); end
            end
            n_checks++; if (core_rvalid_o !== (owner == 1) || dma_rvalid_o !== (owner == 2)) begin n_fail++; $display("FAIL rnd_rvalid[%0d] got c=%b d=%b want owner %0d", cyc, core_rvalid_o, dma_rvalid_o, owner); end
            if (owner == 1) begin core_last = pend; core_known = 1; end
            if (owner == 2) begin dma_last = pend; dma_known = 1; end
            if (core_known) begin
                n_checks++; if (core_rdata_o !== core_last) begin n_fail++; $display("FAIL rnd_core_rdata[%0d] got %h want %h", cyc, core_rdata_o, core_last); end
            end
            if (dma_known) begin
                n_checks++; if (dma_rdata_o !== dma_last) begin n_fail++; $display("FAIL rnd_dma_rdata[%0d] got %h want %h", cyc, dma_rdata_o, dma_last); end
            end

            owner = 0;
            if (cwin || dwin) begin
                logic [7:0] idx; logic [31:0] wd; logic [3:0] be; logic we;
                idx = cwin ? core_addr_i[9:2] : dma_addr_i[9:2];
                wd = cwin ? core_wdata_i : dma_wdata_i;
                be = cwin ? core_be_i : dma_be_i;
                we = cwin ? core_we_i : dma_we_i;
                if (we) begin
                    for (int b = 0; b < 4; b++) if (be[b]) shadow[idx][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    pend = shadow[idx]; owner = cwin ? 1 : 2;
                end
            end
            if (dwin || !dma_req_i) run = 0;
            else if (!bad && cwin && run < MAXRUN) run++;
            if (dwin && dma_lock_i) locked = 1;
            else if (!dma_lock_i) locked = 0;
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bd_we = 0; bd_fill = 1; bd_idx = 0; bd_data = 0;
        mem_rdata_i = 0;
        idle_inputs();
        rst_i = 0;
        @(negedge clk);
        bd_fill = 0;
        test_reset();
        test_core_read();
        test_starvation();
        test_locked_burst();
        test_misaligned();
        test_interleaved_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
